clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
- Sits directly downstream of even_divider / odd_divider.
- Samples a divided clock in the source clock domain and measures its period and high time in clk_in cycles.
- Compares each measurement against an expected divide ratio and reports lock and sticky error status.
- Used in the divider bench and in silicon bring-up to prove each divider output is correct.

Parameters:
CNT_W, 8, width of the ratio, period and high-time counters; timeout occurs at 2^CNT_W-1 cycles
LOCK_CNT, 4, consecutive good measurements required to assert locked

Ports:
clk_in  input  1  source clock, the same clock that drives the dividers
rst  input  1  synchronous reset, active-high
en  input  1  monitor enable; low forces IDLE
div_clk_in  input  1  divided clock under test, sampled as data
exp_div  input  CNT_W  expected divide ratio N; legal range N>=2
err_clr  input  1  clears the sticky err flag
period_cnt  output  CNT_W  last measured period, in clk_in cycles
high_cnt  output  CNT_W  last measured high time, in clk_in cycles
meas_valid  output  1  one-cycle pulse when period_cnt and high_cnt update
locked  output  1  LOCK_CNT consecutive good measurements seen
err  output  1  sticky error flag

Behaviour:
- Reset, or en=0: period_cnt=0, high_cnt=0, meas_valid=0, locked=0, good counter=0, state=IDLE.
  - Reset also clears err and both sample flops.
  - en=0 holds err at its current value.
- Sampling:
  - s1 <= div_clk_in; s2 <= s1.
  - rise = s1 & ~s2. No synchronizer is needed because the input originates from clk_in.
- States:
  - IDLE -> ACQ when en=1.
  - ACQ: wait for the first rise, then load cnt=1 and h=1 and go to MEAS. No measurement is produced on this rise.
  - MEAS, on a non-rise cycle: cnt <= cnt+1, saturating; h <= h+s1, saturating.
  - MEAS, on a rise cycle: period_cnt <= cnt, high_cnt <= h, meas_valid <= 1, cnt <= 1, h <= 1.
- Latency: a divided-clock rising edge produces meas_valid 2 clk_in edges later (1 sample flop plus 1 output register).
- Good measurement: period==exp_div AND |2*high - period| <= 1.
  - For even N this means exactly 50% duty.
  - For odd N, high time of (N-1)/2 or (N+1)/2 is accepted, because the half-cycle high time of a 50%-duty odd divider quantises when sampled on posedge.
- Lock tracking:
  - Good measurement: good counter increments, saturating at LOCK_CNT. When it reaches LOCK_CNT, locked=1 in the same update.
  - Bad measurement: good counter=0, locked=0, err=1.
- exp_div<2: every measurement is bad.
- Timeout: if cnt reaches 2^CNT_W-1 in MEAS (no rise seen):
  - err=1, locked=0, good counter=0.
  - State -> ACQ, no meas_valid.
- err_clr:
  - Clears err on the next edge.
  - If a new error event occurs in the same cycle, the error wins and err stays 1.
- en dropped mid-measurement: partial counts are discarded. Re-enabling restarts at ACQ.
- exp_div change while locked: takes effect on the next measurement. If that measurement is bad, lock is dropped.

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, ACQ, MEAS};
  - default CNT_W and LOCK_CNT localparams;
  - a function duty_ok(period, high) implementing the 50% ±1 rule.
- Sub-module rise_detect: the s1/s2 flops plus the rise output; to be shared with future edge monitors.

Test Plan:
- Even divide: even_divider at N=4, exp_div=4, en=1 after reset -> every meas_valid shows period_cnt=4, high_cnt=2; locked=1 on the 4th measurement (5th rise); err=0.
- Odd divide: odd_divider at N=5, exp_div=5 -> period_cnt=5, high_cnt in {2,3}; locked=1 after 4 measurements; err=0.
- Ratio mismatch: divider N=4, exp_div=6 -> first meas_valid gives period_cnt=4, err=1, locked=0. Pulse err_clr -> err=0 for one cycle, then err=1 again on the next measurement.
- Stuck input: hold div_clk_in=0 after lock with CNT_W=8 -> 255 cycles after the last rise err=1, locked=0, state returns to ACQ, no meas_valid.
- Reset mid-operation: assert rst for 1 cycle while locked and err=1 -> next edge shows all outputs 0. After release, the first meas_valid appears one divided period after the first rise, and lock is reacquired after 4 good measurements.
- Simultaneous events: err_clr asserted in the same cycle as a bad measurement -> err remains 1. exp_div=1 -> every measurement flags err.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types, defaults and the duty-cycle rule for the divider monitor.
package clk_div_pkg;

   localparam int CNT_W_DEF    = 8;
   localparam int LOCK_CNT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      MEAS = 2'd2
   } state_t;

   // 50% duty within one clk_in cycle: |2*high - period| <= 1.
   // Odd ratios sampled on posedge land on (N-1)/2 or (N+1)/2.
   function automatic logic duty_ok(input int period, input int high);
      int diff;
      diff = (2 * high) - period;
      return (diff >= -1) && (diff <= 1);
   endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Control and status bundle between the monitor and whoever drives it.
interface clk_div_monitor_if
   import clk_div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             en;
   logic             div_clk_in;
   logic [CNT_W-1:0] exp_div;
   logic             err_clr;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic             meas_valid;
   logic             locked;
   logic             err;

   modport master (
      output en, div_clk_in, exp_div, err_clr,
      input  period_cnt, high_cnt, meas_valid, locked, err
   );

   modport slave (
      input  en, div_clk_in, exp_div, err_clr,
      output period_cnt, high_cnt, meas_valid, locked, err
   );
endinterface

// File: rtl/rise_detect.sv
// Two-flop sampler of a clk_in-domain level with a rising-edge strobe.
// The input is generated from clk_in, so no synchronizer is required.
module rise_detect (
   input  logic clk_in,
   input  logic rst,
   input  logic d,
   output logic s1,
   output logic rise
);
   logic s2;

   // Sample the level and keep one cycle of history.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end

   assign rise = s1 & ~s2;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in clk_in cycles and
// tracks lock / sticky error against the expected divide ratio.
module clk_div_monitor
   import clk_div_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   clk_div_monitor_if.slave bus
);
   localparam int               GW      = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic [CNT_W-1:0] cnt, h;
   logic [CNT_W-1:0] period_q, high_q;
   logic             meas_valid_q, locked_q, err_q;
   logic [GW-1:0]    good_cnt;
   logic             s1, rise;
   logic             meas_good, timeout, err_event;

   rise_detect u_rise (
      .clk_in (clk_in),
      .rst    (rst),
      .d      (bus.div_clk_in),
      .s1     (s1),
      .rise   (rise)
   );

   // Judge the running measurement and flag error events for this edge.
   always_comb begin
      meas_good = (bus.exp_div >= CNT_W'(2)) && (cnt == bus.exp_div) &&
                  duty_ok(int'(cnt), int'(h));
      timeout   = (state == MEAS) && !rise && (cnt == CNT_MAX);
      err_event = ((state == MEAS) && rise && !meas_good) || timeout;
   end

   // Acquisition/measurement FSM with registered status outputs.
   always_ff @(posedge clk_in) begin
      if (rst || !bus.en) begin
         state        <= IDLE;
         cnt          <= '0;
         h            <= '0;
         period_q     <= '0;
         high_q       <= '0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         good_cnt     <= '0;
         if (rst) err_q <= 1'b0;   // disable alone keeps the sticky flag
      end else begin
         meas_valid_q <= 1'b0;
         if (err_event)        err_q <= 1'b1;
         else if (bus.err_clr) err_q <= 1'b0;
         case (state)
            IDLE: state <= ACQ;
            ACQ: begin
               // First edge only opens a window; nothing to report yet.
               if (rise) begin
                  cnt   <= CNT_W'(1);
                  h     <= CNT_W'(1);
                  state <= MEAS;
               end
            end
            MEAS: begin
               if (rise) begin
                  period_q     <= cnt;
                  high_q       <= h;
                  meas_valid_q <= 1'b1;
                  cnt          <= CNT_W'(1);
                  h            <= CNT_W'(1);
                  if (meas_good) begin
                     if (good_cnt >= GW'(LOCK_CNT - 1)) begin
                        good_cnt <= GW'(LOCK_CNT);
                        locked_q <= 1'b1;
                     end else begin
                        good_cnt <= good_cnt + 1'b1;
                     end
                  end else begin
                     good_cnt <= '0;
                     locked_q <= 1'b0;
                  end
               end else if (timeout) begin
                  // Divided clock stalled: drop the window and reacquire.
                  good_cnt <= '0;
                  locked_q <= 1'b0;
                  state    <= ACQ;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (s1 && (h != CNT_MAX)) h <= h + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.period_cnt = period_q;
   assign bus.high_cnt   = high_q;
   assign bus.meas_valid = meas_valid_q;
   assign bus.locked     = locked_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized + directed bench for clk_div_monitor with a scoreboard.
module tb_clk_div_monitor;
   import clk_div_pkg::*;

   localparam int CNT_W = 8;
   localparam int LOCK  = 4;

   logic clk_in = 1'b0;
   logic rst    = 1'b1;

   clk_div_monitor_if #(.CNT_W(CNT_W)) bus ();

   clk_div_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int p;
      int h;
      bit locked;
      bit err;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model: one divided cycle (p,h) pending, closed by the next rise.
   bit pend   = 1'b0;
   int pp     = 0;
   int ph     = 0;
   int good_m = 0;
   bit err_m  = 1'b0;

   task automatic chk(input string nm, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
   endtask

   function automatic bit ref_good(input int p, input int h, input int n);
      return (n >= 2) && (p == n) && (2 * h - p <= 1) && (p - 2 * h <= 1);
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // A rise closes the pending cycle: predict the resulting measurement.
   task automatic close_meas(input bit clr);
      bit g;
      if (pend) begin
         g = ref_good(pp, ph, int'(bus.exp_div));
         if (g) begin
            good_m = (good_m + 1 > LOCK) ? LOCK : good_m + 1;
            if (clr) err_m = 1'b0;
         end else begin
            good_m = 0;
            err_m  = 1'b1;
         end
         sb.push_back('{p: pp, h: ph, locked: (good_m == LOCK), err: err_m});
      end else if (clr) begin
         err_m = 1'b0;
      end
   endtask

   // One divided-clock cycle: h high, p-h low. clr_rise holds err_clr across
   // the edge that judges the previous cycle; clr_low pulses it in the low phase.
   task automatic div_cycle(input int p, input int h, input bit clr_rise, input bit clr_low);
      bit do_low;
      close_meas(clr_rise);
      pend   = 1'b1;
      pp     = p;
      ph     = h;
      do_low = clr_low && (p >= 3);
      for (int i = 0; i < p; i++) begin
         bus.div_clk_in = (i < h);
         bus.err_clr    = (clr_rise && i < 2) || (do_low && i == p - 1);
         step();
      end
      bus.err_clr = 1'b0;
      if (do_low) begin
         err_m = 1'b0;
         chk("err_clr_low", int'(bus.err), 0);
      end
   endtask

   task automatic gap(input int n);
      bus.div_clk_in = 1'b0;
      repeat (n) step();
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_period"}, int'(bus.period_cnt), 0);
      chk({nm, "_high"},   int'(bus.high_cnt), 0);
      chk({nm, "_mvalid"}, int'(bus.meas_valid), 0);
      chk({nm, "_locked"}, int'(bus.locked), 0);
   endtask

   // Scoreboard monitor: compare every reported measurement.
   always @(negedge clk_in) begin
      if (bus.meas_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_meas", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("period", int'(bus.period_cnt), e.p);
            chk("high",   int'(bus.high_cnt),   e.h);
            chk("locked", int'(bus.locked),     int'(e.locked));
            chk("err",    int'(bus.err),        int'(e.err));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, h, sel;
      bus.en         = 1'b0;
      bus.div_clk_in = 1'b0;
      bus.exp_div    = CNT_W'(4);
      bus.err_clr    = 1'b0;
      rst            = 1'b1;
      repeat (3) step();
      chk_all_zero("reset");
      chk("reset_err", int'(bus.err), 0);
      rst = 1'b0;

      // Even divide by 4.
      bus.en = 1'b1;
      gap(3);
      for (int i = 0; i < 8; i++) div_cycle(4, 2, 0, 0);
      chk("even_locked", int'(bus.locked), 1);

      // Ratio mismatch, clear in the low phase, error returns.
      bus.exp_div = CNT_W'(6);
      for (int i = 0; i < 3; i++) div_cycle(4, 2, 0, i == 1);

      // Odd divide by 5, high time 2 or 3.
      bus.exp_div = CNT_W'(5);
      for (int i = 0; i < 8; i++) div_cycle(5, ($urandom % 2) ? 3 : 2, 0, i == 0);
      chk("odd_locked", int'(bus.locked), 1);
      chk("odd_err", int'(bus.err), 0);

      // err_clr coincident with a bad measurement: error wins.
      div_cycle(4, 2, 0, 0);
      div_cycle(5, 2, 1, 0);
      for (int i = 0; i < 6; i++) div_cycle(5, 3, 0, i == 0);
      chk("relock_before_stuck", int'(bus.locked), 1);

      // Stuck input after lock: timeout 257 edges after the final high is driven.
      close_meas(0);
      pend = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         bus.div_clk_in = (k <= 2);
         step();
      end
      chk("pre_timeout_err", int'(bus.err), 0);
      chk("pre_timeout_locked", int'(bus.locked), 1);
      step();
      chk("timeout_err", int'(bus.err), 1);
      chk("timeout_locked", int'(bus.locked), 0);
      err_m  = 1'b1;
      good_m = 0;

      // Relock with err still set, then reset mid-operation.
      bus.exp_div = CNT_W'(4);
      for (int i = 0; i < 6; i++) div_cycle(4, 2, 0, 0);
      chk("prereset_locked", int'(bus.locked), 1);
      chk("prereset_err", int'(bus.err), 1);
      bus.div_clk_in = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_all_zero("midreset");
      chk("midreset_err", int'(bus.err), 0);
      pend = 1'b0; good_m = 0; err_m = 1'b0;
      gap(3);
      for (int i = 0; i < 6; i++) div_cycle(4, 2, 0, 0);

      // exp_div below 2: every measurement is bad.
      bus.exp_div = CNT_W'(1);
      for (int i = 0; i < 4; i++) div_cycle(2, 1, 0, 0);

      // Enable dropped mid-measurement: partial window discarded, err held.
      bus.exp_div = CNT_W'(4);
      for (int i = 0; i < 6; i++) div_cycle(4, 2, 0, i == 1);
      div_cycle(4, 2, 0, 0);
      bus.en = 1'b0;
      step();
      chk_all_zero("en_drop");
      chk("en_drop_err", int'(bus.err), int'(err_m));
      pend = 1'b0; good_m = 0;
      gap(2);
      bus.en = 1'b1;
      gap(3);

      // Randomized cycles with mostly-correct expected ratios.
      for (int i = 0; i < 60; i++) begin
         p   = int'($urandom_range(2, 12));
         sel = int'($urandom % 4);
         case (sel)
            0, 1:    h = p / 2;
            2:       h = (p + 1) / 2;
            default: h = int'($urandom_range(1, p - 1));
         endcase
         if ($urandom % 4 != 0) bus.exp_div = CNT_W'(pp);
         else                   bus.exp_div = CNT_W'($urandom_range(0, 12));
         div_cycle(p, h, ($urandom % 6) == 0, ($urandom % 5) == 0);
      end

      gap(4);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
